// File: rtl/inpass4_sync_filter.sv
// Four-channel pad input BEL: per-channel bypass / register / synchronizer / glitch filter.
// Optional macro INPASS_SYNC3_EN adds a third synchronizer stage ahead of mode 10 and the filter.
module inpass4_sync_filter #(
  parameter int unsigned NoConfigBits = 10,
  parameter int unsigned FILTER_W     = 4
) (
  input  logic                    UserCLK,
  input  logic                    UserRST_N,
  input  logic [3:0]              I,
  output logic [3:0]              O,
  input  logic [NoConfigBits-1:0] ConfigBits
);

  localparam int unsigned NumCh = 4;
  localparam int unsigned CntW  = FILTER_W + 1;

  logic [NumCh-1:0]               reg_q, reg_d;
  logic [NumCh-1:0]               s1_q, s1_d;
  logic [NumCh-1:0]               s2_q, s2_d;
  logic [NumCh-1:0]               filt_q, filt_d;
  logic [NumCh-1:0][FILTER_W-1:0] cnt_q, cnt_d;
  logic [NumCh-1:0]               sync_out_c;
  logic [CntW-1:0]                thr_c;
  logic [CntW-1:0]                cnt_inc_c;

`ifdef INPASS_SYNC3_EN
  logic [NumCh-1:0] s3_q, s3_d;
  assign s3_d       = s2_q;
  assign sync_out_c = s3_q;
`else
  assign sync_out_c = s2_q;
`endif

  // Shared filter threshold decode.
  always_comb begin
    thr_c = CntW'(2);
    case (ConfigBits[9:8])
      2'b00:   thr_c = CntW'(2);
      2'b01:   thr_c = CntW'(4);
      2'b10:   thr_c = CntW'(8);
      default: thr_c = CntW'(15);
    endcase
  end

  // Next-state: every stage advances each cycle independent of mode.
  always_comb begin
    reg_d     = I;
    s1_d      = I;
    s2_d      = s1_q;
    filt_d    = filt_q;
    cnt_d     = cnt_q;
    cnt_inc_c = '0;
    for (int i = 0; i < NumCh; i++) begin
      cnt_inc_c = CntW'(cnt_q[i]) + CntW'(1);
      if (sync_out_c[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_inc_c >= thr_c) begin
        filt_d[i] = sync_out_c[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_inc_c[FILTER_W-1:0];
      end
    end
  end

  always_ff @(posedge UserCLK or negedge UserRST_N) begin
    if (!UserRST_N) begin
      reg_q  <= '0;
      s1_q   <= '0;
      s2_q   <= '0;
      filt_q <= '0;
      cnt_q  <= '0;
    end else begin
      reg_q  <= reg_d;
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

`ifdef INPASS_SYNC3_EN
  always_ff @(posedge UserCLK or negedge UserRST_N) begin
    if (!UserRST_N) begin
      s3_q <= '0;
    end else begin
      s3_q <= s3_d;
    end
  end
`endif

  // Output mux is purely combinational so a mode change needs no flush.
  always_comb begin
    O = '0;
    for (int i = 0; i < NumCh; i++) begin
      case (ConfigBits[2*i +: 2])
        2'b00:   O[i] = I[i];
        2'b01:   O[i] = reg_q[i];
        2'b10:   O[i] = sync_out_c[i];
        default: O[i] = filt_q[i];
      endcase
    end
  end

endmodule
